// File: rtl/ldtu_rx_idle_strip_fifo_if.sv
// Word-stream and read-side bus between a DTU receiver and its downstream consumer.
// The receiver takes the slave view and the consumer or bench takes the master view.
interface ldtu_rx_idle_strip_fifo_if #(
  parameter int unsigned W = 32
);
  logic [W-1:0] data_in_32;
  logic         data_valid;
  logic         rd_en;
  logic [W-1:0] data_out;
  logic         data_out_valid;
  logic         empty_signal;
  logic         full_signal;

  modport master (
    output data_in_32, data_valid, rd_en,
    input  data_out, data_out_valid, empty_signal, full_signal
  );

  modport slave (
    input  data_in_32, data_valid, rd_en,
    output data_out, data_out_valid, empty_signal, full_signal
  );
endinterface

// File: rtl/ldtu_rx_idle_strip_fifo.sv
// DTU receive stage: locks on the idle stream, strips idle words and buffers data words.
// Downstream logic drains the buffered words with a read strobe.
module ldtu_rx_idle_strip_fifo #(
  parameter int unsigned        Nbits_32       = 32,
  parameter int unsigned        FifoDepth      = 16,
  parameter int unsigned        bits_ptr       = 4,
  parameter logic [Nbits_32-1:0] idle_patternEA = 32'hEAAAAAAA,
  parameter logic [Nbits_32-1:0] idle_pattern5A = 32'h5A5A5A5A,
  parameter int unsigned        LockIdleCount  = 4
) (
  input  logic        CLK,
  input  logic        reset,
  ldtu_rx_idle_strip_fifo_if.slave bus,
  output logic        locked,
  output logic        overflow,
  output logic [15:0] word_count,
  output logic [15:0] idle_count
);

  localparam int unsigned CntW = bits_ptr + 1;
  localparam int unsigned RunW = 4;

  typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

  state_t              state, state_nxt;
  logic [RunW-1:0]     run_q, run_nxt;
  logic [bits_ptr-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0]     cnt_q, cnt_nxt;
  logic [Nbits_32-1:0] mem [FifoDepth];
  logic [Nbits_32-1:0] dout_q;
  logic                valid_q, empty_q, full_q;
  logic                is_idle_c, is_data_c, pop_c, wr_c, drop_c, idle_hit_c;

  assign is_idle_c = bus.data_valid &&
                     (bus.data_in_32 == idle_patternEA || bus.data_in_32 == idle_pattern5A);
  assign is_data_c = bus.data_valid && !is_idle_c;
  // No fall-through: pops are gated by the registered empty flag.
  assign pop_c     = bus.rd_en && !empty_q;
  assign cnt_nxt   = cnt_q + CntW'(wr_c) - CntW'(pop_c);

  always_ff @(posedge CLK) begin
    if (reset) state <= ST_HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HUNT:   if (is_idle_c && run_q == RunW'(LockIdleCount - 1)) state_nxt = ST_LOCKED;
      ST_LOCKED: if (is_data_c && full_q && !pop_c) state_nxt = ST_HUNT;
      default:   state_nxt = ST_HUNT;
    endcase
  end

  always_comb begin
    wr_c       = 1'b0;
    drop_c     = 1'b0;
    idle_hit_c = 1'b0;
    run_nxt    = run_q;
    case (state)
      ST_HUNT: begin
        if (is_idle_c) begin
          run_nxt = (run_q == RunW'(LockIdleCount - 1)) ? '0 : run_q + RunW'(1);
        end else if (is_data_c) begin
          run_nxt = '0;
        end
      end
      ST_LOCKED: begin
        run_nxt = '0;
        if (is_idle_c) idle_hit_c = 1'b1;
        else if (is_data_c) begin
          if (!full_q || pop_c) wr_c = 1'b1;
          else                  drop_c = 1'b1;
        end
      end
      default: run_nxt = '0;
    endcase
  end

  // Storage carries no reset; contents are unreachable once the pointers clear.
  always_ff @(posedge CLK) begin
    if (wr_c) mem[wr_ptr] <= bus.data_in_32;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      run_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt_q      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      dout_q     <= idle_patternEA;
      valid_q    <= 1'b0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      idle_count <= '0;
    end else begin
      run_q   <= run_nxt;
      locked  <= (state_nxt == ST_LOCKED);
      valid_q <= pop_c;
      cnt_q   <= cnt_nxt;
      empty_q <= (cnt_nxt == CntW'(0));
      full_q  <= (cnt_nxt == CntW'(FifoDepth));
      if (wr_c) wr_ptr <= wr_ptr + bits_ptr'(1);
      if (pop_c) begin
        rd_ptr <= rd_ptr + bits_ptr'(1);
        dout_q <= mem[rd_ptr];
      end
      if (drop_c) overflow <= 1'b1;
      if (wr_c && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
      if (idle_hit_c && idle_count != 16'hFFFF) idle_count <= idle_count + 16'd1;
    end
  end

  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = valid_q;
  assign bus.empty_signal   = empty_q;
  assign bus.full_signal    = full_q;

endmodule

// File: doc/ldtu_rx_idle_strip_fifo.md
Name: ldtu_rx_idle_strip_fifo

Overview:
Receive-side counterpart of the LiTe-DTU output FIFO stage. It sits at the back-end end of the 32-bit DTU word stream and samples one word per CLK when data_valid is high. It locks on the idle stream (0xEAAAAAAA / 0x5A5A5A5A), drops idle words, and buffers real data words in a FIFO that downstream logic drains with a read strobe. Overflow, lock state and word/idle statistics are reported.

Parameters:
Nbits_32, 32, data word width
FifoDepth, 16, FIFO depth in words (power of 2)
bits_ptr, 4, pointer width = log2(FifoDepth)
idle_patternEA, 32'hEAAAAAAA, idle word A
idle_pattern5A, 32'h5A5A5A5A, idle word B
LockIdleCount, 4, consecutive idle words needed to lock (1..15)

Ports:
CLK  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
data_in_32  input  32  received DTU word
data_valid  input  1  data_in_32 holds a word this cycle
rd_en  input  1  read request from downstream
data_out  output  32  FIFO read data, registered
data_out_valid  output  1  1-cycle pulse, data_out updated this cycle
empty_signal  output  1  FIFO holds 0 words
full_signal  output  1  FIFO holds FifoDepth words
locked  output  1  receiver is in LOCKED state
overflow  output  1  sticky: a data word was dropped because the FIFO was full
word_count  output  16  data words written to the FIFO, saturating at 0xFFFF
idle_count  output  16  idle words dropped while LOCKED, saturating at 0xFFFF

Behaviour:
- Reset (reset=1 at a CLK edge) is synchronous and active-high. It forces data_out=idle_patternEA, data_out_valid=0, empty_signal=1, full_signal=0, locked=0, overflow=0, and both counters=0. It clears the pointers and the idle run counter and puts the FSM in HUNT. A reset mid-operation discards FIFO contents.
- Idle word: data_valid=1 and data_in_32 equals idle_patternEA or idle_patternEA5A. Data word: data_valid=1 and the word is not idle. A cycle with data_valid=0 is ignored by every rule below.
- FSM states:
  - HUNT:
    - Each idle word increments the run counter; a data word clears it.
    - When an idle word makes run == LockIdleCount, go to LOCKED; locked=1 from the next cycle.
    - In HUNT, all words are discarded and the FIFO is not written.
  - LOCKED:
    - Idle word: dropped; idle_count increments.
    - Data word with FIFO not full, or full with rd_en in the same cycle: written at this edge; word_count increments.
    - Data word with FIFO full and no rd_en: dropped; overflow=1 (sticky); go to HUNT with run=0; locked=0 next cycle.
- Write latency: a data word sampled at edge t makes empty_signal=0 after edge t. The earliest read is rd_en at edge t+1, giving data_out/data_out_valid after edge t+1.
- Read: rd_en=1 with empty_signal=0 pops the oldest word into data_out and pulses data_out_valid for one cycle. rd_en with empty_signal=1 is ignored: no pop, data_out_valid=0, data_out holds. There is no fall-through: a write and a read in the same cycle on an empty FIFO pop nothing.
- Full/empty are registered and computed from an occupancy count (0..FifoDepth). A simultaneous write+pop leaves the count unchanged. Pointers wrap modulo FifoDepth.
- data_out holds its last value between pops.
- Counters saturate and never wrap.
- Order is strictly preserved; no word is duplicated.

Test Plan:
1. Reset, then 3 EA words then data 0x00000001 -> locked stays 0, FIFO stays empty, word_count=0. Then 4 EA words -> locked=1 on the cycle after the 4th.
2. After lock, send 0x11111111, 0x5A5A5A5A, 0x22222222, 0xEAAAAAAA, 0x33333333. Then rd_en for 4 cycles -> data_out pulses 0x11111111, 0x22222222, 0x33333333; the 4th rd_en gives no pulse; word_count=3, idle_count=2.
3. Locked with no reads: 16 data words -> full_signal=1. A 17th word -> overflow=1, locked=0, word_count=16. Draining returns the first 16 words in order.
4. Full FIFO with rd_en and a data word in the same cycle -> word accepted, full_signal stays 1, overflow stays 0, the oldest word is popped.
5. data_valid=0 gaps inside the lock run (EA, gap, EA, EA, gap, EA) -> locks after the 4th EA. A gap between data words inserts nothing.
6. reset pulsed with 5 words buffered and overflow=1 -> the next cycle shows empty_signal=1, overflow=0, locked=0, data_out=0xEAAAAAAA, counters=0.
